// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-level round-robin stream multiplexer.
package stream_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Source-index width; never narrower than one bit so N=1 still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping modulo N.
module rr_picker
    import stream_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    localparam int unsigned DW = 2 * N;

    logic [N-1:0]  hi_mask;
    logic [DW-1:0] dbl;
    logic          found;
    logic [IW-1:0] found_idx;

    // Lower half keeps only requesters after ptr; upper half is the wrapped second lap.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (IW'(i) > ptr);
        end
        dbl = {req, req & hi_mask};
    end

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned j = 0; j < DW; j++) begin
            if (!found && dbl[j]) begin
                found     = 1'b1;
                found_idx = (j >= N) ? IW'(j - N) : IW'(j);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt[i] = found && (found_idx == IW'(i));
        end
        gnt_idx = found_idx;
        any     = found;
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input packet-level round-robin stream multiplexer with a registered single-entry output slot.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned W  = 64,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [IW-1:0]  out_src,
    input  logic           out_ready
);

    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_q, lock_d;
    logic          settle_q, settle_d;

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic          last_q, last_d;
    logic [IW-1:0] src_q, src_d;

    logic          free;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] sel;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          hs;

    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Source select, beat fan-in and ready steering.
    always_comb begin
        free     = !valid_q || out_ready;
        sel      = (state_q == ST_LOCKED) ? lock_q : pick_idx;
        sel_data = '0;
        sel_last = 1'b0;
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
            end
        end
        if (state_q == ST_LOCKED) begin
            for (int unsigned i = 0; i < N; i++) begin
                in_ready[i] = free && (lock_q == IW'(i));
            end
        end else if (!settle_q && pick_any) begin
            // One arbitration bubble follows every multi-beat packet.
            in_ready = pick_gnt & {N{free}};
        end
        hs = |(in_valid & in_ready);
    end

    // Packet lock FSM and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        lock_d   = lock_q;
        settle_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    ptr_d  = sel;
                    lock_d = sel;
                    if (!sel_last) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (hs && sel_last) begin
                    state_d  = ST_IDLE;
                    settle_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output slot: load on handshake, drain when downstream accepts.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        src_d   = src_q;
        if (hs) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            last_d  = sel_last;
            src_d   = sel;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            lock_q   <= '0;
            settle_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            lock_q   <= lock_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            src_q    <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: directed packets into N=4, N=3 and N=2 instances.
module tb_stream_arb_mux;

    localparam int unsigned W = 16;

    typedef struct {
        int           src;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;
    int   sel;

    logic [3:0]   e_valid;
    logic [3:0]   e_last;
    logic [W-1:0] e_data [4];
    logic         o_ready;
    logic         ready_next;
    logic [3:0]   acc;

    logic [3:0]     v4, l4, r4;
    logic [4*W-1:0] d4;
    logic           ov4, ol4;
    logic [W-1:0]   od4;
    logic [1:0]     os4;

    logic [2:0]     v3, l3, r3;
    logic [3*W-1:0] d3;
    logic           ov3, ol3;
    logic [W-1:0]   od3;
    logic [1:0]     os3;

    logic [1:0]     v2, l2, r2;
    logic [2*W-1:0] d2;
    logic           ov2, ol2;
    logic [W-1:0]   od2;
    logic [0:0]     os2;

    logic [3:0]   rdy;
    logic         o_valid, o_last;
    logic [W-1:0] o_data;
    int           o_src;

    int    plen [4];
    int    pkts [4];
    int    beat [4];
    int    pkno [4];
    int    gap  [4];
    int    pause_src, pause_beat, pause_len;
    beat_t sbq [$];
    beat_t mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    t1_v [7] = '{1, 1, 1, 0, 1, 1, 1};

    always #5 clk = ~clk;

    assign v4 = (sel == 4) ? e_valid : 4'b0;
    assign l4 = e_last;
    assign d4 = {e_data[3], e_data[2], e_data[1], e_data[0]};
    assign v3 = (sel == 3) ? e_valid[2:0] : 3'b0;
    assign l3 = e_last[2:0];
    assign d3 = {e_data[2], e_data[1], e_data[0]};
    assign v2 = (sel == 2) ? e_valid[1:0] : 2'b0;
    assign l2 = e_last[1:0];
    assign d2 = {e_data[1], e_data[0]};

    assign rdy     = (sel == 4) ? r4 : (sel == 3) ? {1'b0, r3} : {2'b00, r2};
    assign o_valid = (sel == 4) ? ov4 : (sel == 3) ? ov3 : ov2;
    assign o_last  = (sel == 4) ? ol4 : (sel == 3) ? ol3 : ol2;
    assign o_data  = (sel == 4) ? od4 : (sel == 3) ? od3 : od2;
    assign o_src   = (sel == 4) ? int'(os4) : (sel == 3) ? int'(os3) : int'(os2);

    stream_arb_mux #(.N(4), .W(W)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(v4), .in_data(d4), .in_last(l4), .in_ready(r4),
        .out_valid(ov4), .out_data(od4), .out_last(ol4), .out_src(os4), .out_ready(o_ready)
    );
    stream_arb_mux #(.N(3), .W(W)) dut3 (
        .clk(clk), .rstn(rstn), .in_valid(v3), .in_data(d3), .in_last(l3), .in_ready(r3),
        .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_src(os3), .out_ready(o_ready)
    );
    stream_arb_mux #(.N(2), .W(W)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_data(d2), .in_last(l2), .in_ready(r2),
        .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_src(os2), .out_ready(o_ready)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_data(input int src, input int pk, input int b);
        return W'((src << 12) | (pk << 8) | b);
    endfunction

    task automatic push_beat(input int src, input int pk, input int b, input logic last);
        beat_t e;
        e.src  = src;
        e.data = mk_data(src, pk, b);
        e.last = last;
        sbq.push_back(e);
    endtask

    task automatic exp_pkt(input int src, input int pk, input int len);
        for (int b = 0; b < len; b++) begin
            push_beat(src, pk, b, b == len - 1);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (gap[i] > 0) begin
                e_valid[i] = 1'b0;
                gap[i]--;
            end else begin
                e_valid[i] = (pkts[i] > 0);
            end
            e_data[i] = mk_data(i, pkno[i], beat[i]);
            e_last[i] = (beat[i] == plen[i] - 1);
        end
    endtask

    // One clock: retire last cycle's handshakes, drive new beats, sample handshakes at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (e_last[i]) begin
                    beat[i] = 0;
                    pkno[i]++;
                    pkts[i]--;
                end else begin
                    if (i == pause_src && beat[i] == pause_beat) gap[i] = pause_len;
                    beat[i]++;
                end
            end
        end
        o_ready = ready_next;
        drive();
        @(negedge clk);
        acc = e_valid & rdy;
    endtask

    task automatic clear_engine();
        for (int i = 0; i < 4; i++) begin
            plen[i] = 1;
            pkts[i] = 0;
            beat[i] = 0;
            pkno[i] = 0;
            gap[i]  = 0;
        end
        pause_src  = -1;
        pause_beat = 0;
        pause_len  = 0;
        acc        = 4'b0;
        drive();
    endtask

    task automatic reset_dut(input int n);
        #2;
        rstn       = 1'b0;
        sel        = n;
        ready_next = 1'b1;
        o_ready    = 1'b1;
        clear_engine();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(sbq.size()), 32'd0);
        sbq.delete();
        repeat (3) cyc();
    endtask

    // Scoreboard monitor: every accepted output beat must match the next expected beat.
    always @(negedge clk) begin
        if (rstn && o_valid && o_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: got src %0d data %h last %0b, expected no beat (t=%0t)",
                         o_src, o_data, o_last, $time);
            end else begin
                mon_e = sbq.pop_front();
                if (o_src != mon_e.src || o_data !== mon_e.data || o_last !== mon_e.last) begin
                    n_bad++;
                    $display("FAIL sb_beat: got src %0d data %h last %0b, expected src %0d data %h last %0b (t=%0t)",
                             o_src, o_data, o_last, mon_e.src, mon_e.data, mon_e.last, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        sel  = 4;

        // Reset state
        reset_dut(4);
        chk("rst_out_valid", 32'(o_valid), 32'd0);
        chk("rst_out_data", 32'(o_data), 32'd0);
        chk("rst_out_last", 32'(o_last), 32'd0);
        chk("rst_out_src", 32'(o_src), 32'd0);
        chk("rst_in_ready", 32'(rdy), 32'd0);

        // Two simultaneous 3-beat packets: src 0 first, one bubble, then src 2
        plen[0] = 3; pkts[0] = 1;
        plen[2] = 3; pkts[2] = 1;
        exp_pkt(0, 0, 3);
        exp_pkt(2, 0, 3);
        cyc();
        chk("t1_first_ready", 32'(rdy), 32'h1);
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk("t1_out_valid", 32'(o_valid), 32'(t1_v[k]));
            if (k == 2) chk("t1_settle_ready", 32'(rdy), 32'h0);
            if (k == 3) chk("t1_second_ready", 32'(rdy), 32'h4);
            if (k == 2 || k == 6) chk("t1_out_last", 32'(o_last), 32'd1);
        end
        drain("t1_drain", 20);

        // All requesters, single-beat packets: one grant per cycle in rotation
        reset_dut(4);
        for (int i = 0; i < 4; i++) begin
            plen[i] = 1;
            pkts[i] = 2;
        end
        for (int k = 0; k < 8; k++) exp_pkt(k % 4, k / 4, 1);
        cyc();
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t2_out_valid", 32'(o_valid), 32'd1);
            chk("t2_out_src", 32'(o_src), 32'(k % 4));
        end
        drain("t2_drain", 20);

        // Backpressure for 5 cycles in the middle of a 4-beat packet from src 1
        reset_dut(4);
        plen[1] = 4; pkts[1] = 1;
        exp_pkt(1, 0, 4);
        repeat (3) cyc();
        ready_next = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t3_stall_valid", 32'(o_valid), 32'd1);
            chk("t3_stall_data", 32'(o_data), 32'h1002);
            chk("t3_stall_src", 32'(o_src), 32'd1);
            chk("t3_stall_last", 32'(o_last), 32'd0);
            chk("t3_stall_ready", 32'(rdy), 32'h0);
        end
        ready_next = 1'b1;
        drain("t3_drain", 20);

        // Lock holds across a 2-cycle bubble from src 0 while src 1 waits (N=2)
        reset_dut(2);
        plen[0] = 3; pkts[0] = 1;
        plen[1] = 2; pkts[1] = 1;
        pause_src = 0; pause_beat = 0; pause_len = 2;
        exp_pkt(0, 0, 3);
        exp_pkt(1, 0, 2);
        cyc();
        chk("t4_first_ready", 32'(rdy), 32'h1);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t4_lock_ready1", 32'(rdy[1]), 32'd0);
        end
        drain("t4_drain", 30);

        // Wrap-around (N=3): after src 2's packet, src 0 beats src 2
        reset_dut(3);
        plen[1] = 2; pkts[1] = 1;
        plen[2] = 2; pkts[2] = 1;
        exp_pkt(1, 0, 2);
        exp_pkt(2, 0, 2);
        cyc();
        chk("t5a_first_ready", 32'(rdy), 32'h2);
        drain("t5a_drain", 20);
        plen[0] = 2; pkts[0] = 1;
        pkts[2] = 1;
        exp_pkt(0, 0, 2);
        exp_pkt(2, 1, 2);
        cyc();
        chk("t5b_first_ready", 32'(rdy), 32'h1);
        drain("t5b_drain", 20);

        // Reset mid-packet after beat 2 of 4 from src 1
        reset_dut(4);
        plen[1] = 4; pkts[1] = 1;
        push_beat(1, 0, 0, 1'b0);
        push_beat(1, 0, 1, 1'b0);
        repeat (3) cyc();
        chk("t6_pre_valid", 32'(o_valid), 32'd1);
        #2;
        rstn = 1'b0;
        clear_engine();
        #1;
        chk("t6_rst_out_valid", 32'(o_valid), 32'd0);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_post_valid", 32'(o_valid), 32'd0);
        chk("t6_post_ready", 32'(rdy), 32'h0);
        plen[0] = 1; pkts[0] = 1;
        plen[1] = 1; pkts[1] = 1;
        exp_pkt(0, 0, 1);
        exp_pkt(1, 0, 1);
        cyc();
        chk("t6_first_ready", 32'(rdy), 32'h1);
        cyc();
        chk("t6_first_src", 32'(o_src), 32'd0);
        cyc();
        chk("t6_second_src", 32'(o_src), 32'd1);
        drain("t6_drain", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
